// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module  : uart_arb_pkg
// Brief   : Shared grant encoding and defaults for the UART TX arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

    localparam int DEFAULT_CPU_FIFO_AW = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ECHO = 2'd1,
        GNT_MON  = 2'd2,
        GNT_CPU  = 2'd3
    } gnt_e;

    localparam logic RR_MON = 1'b0;
    localparam logic RR_CPU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_char_fifo.sv
// ============================================================================
// Module  : uart_char_fifo
// Brief   : 8-bit synchronous FIFO, wrapping pointers plus occupancy count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_char_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int         DEPTH      = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push & (count_q != FULL_COUNT);
        do_pop  = pop & (count_q != '0);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Shares the UART TX FIFO write port between echo (top priority),
//           monitor and buffered CPU characters (round-robin).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int CPU_FIFO_AW = DEFAULT_CPU_FIFO_AW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] echo_char,
    input  logic       echo_en,
    output logic       echo_drop,
    input  logic [7:0] mon_char,
    input  logic       mon_valid,
    output logic       mon_ready,
    input  logic [7:0] cpu_char,
    input  logic       cpu_we,
    output logic       cpu_full,
    output logic       cpu_ovf,
    input  logic       tx_fifo_full,
    output logic [7:0] tx_wdata,
    output logic       tx_wten
);

    gnt_e       grant;
    logic       can_issue;
    logic       cpu_empty, cpu_push, cpu_pop;
    logic [7:0] cpu_dout;

    logic       echo_hv_q,   echo_hv_d;
    logic [7:0] echo_data_q, echo_data_d;
    logic       echo_drop_q, echo_drop_d;
    logic       rr_last_q,   rr_last_d;
    logic       tx_wten_q,   tx_wten_d;
    logic [7:0] tx_wdata_q,  tx_wdata_d;
    logic       cpu_ovf_q,   cpu_ovf_d;

    uart_char_fifo #(
        .AW (CPU_FIFO_AW)
    ) u_cpu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_push),
        .din   (cpu_char),
        .pop   (cpu_pop),
        .dout  (cpu_dout),
        .full  (cpu_full),
        .empty (cpu_empty)
    );

    // No grant right after a write, so tx_fifo_full reflects that write.
    always_comb begin
        can_issue = !rst && !tx_fifo_full && !tx_wten_q;
        grant     = GNT_NONE;
        if (can_issue) begin
            if (echo_hv_q) begin
                grant = GNT_ECHO;
            end else if (mon_valid && !cpu_empty) begin
                grant = (rr_last_q == RR_CPU) ? GNT_MON : GNT_CPU;
            end else if (mon_valid) begin
                grant = GNT_MON;
            end else if (!cpu_empty) begin
                grant = GNT_CPU;
            end
        end
    end

    always_comb begin
        echo_hv_d   = echo_hv_q;
        echo_data_d = echo_data_q;
        echo_drop_d = 1'b0;
        if (grant == GNT_ECHO) begin
            echo_hv_d = 1'b0;
        end
        if (echo_en) begin
            if (!echo_hv_q || grant == GNT_ECHO) begin
                echo_hv_d   = 1'b1;
                echo_data_d = echo_char;
            end else begin
                echo_drop_d = 1'b1;
            end
        end
    end

    always_comb begin
        tx_wten_d  = (grant != GNT_NONE);
        tx_wdata_d = tx_wdata_q;
        rr_last_d  = rr_last_q;
        case (grant)
            GNT_ECHO: tx_wdata_d = echo_data_q;
            GNT_MON: begin
                tx_wdata_d = mon_char;
                rr_last_d  = RR_MON;
            end
            GNT_CPU: begin
                tx_wdata_d = cpu_dout;
                rr_last_d  = RR_CPU;
            end
            default: tx_wdata_d = tx_wdata_q;
        endcase
        cpu_ovf_d = cpu_ovf_q | (cpu_we & cpu_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_hv_q   <= 1'b0;
            echo_data_q <= '0;
            echo_drop_q <= 1'b0;
            rr_last_q   <= RR_CPU;
            tx_wten_q   <= 1'b0;
            tx_wdata_q  <= '0;
            cpu_ovf_q   <= 1'b0;
        end else begin
            echo_hv_q   <= echo_hv_d;
            echo_data_q <= echo_data_d;
            echo_drop_q <= echo_drop_d;
            rr_last_q   <= rr_last_d;
            tx_wten_q   <= tx_wten_d;
            tx_wdata_q  <= tx_wdata_d;
            cpu_ovf_q   <= cpu_ovf_d;
        end
    end

    // A write while full is refused even if a pop frees a slot this cycle.
    assign cpu_push  = cpu_we & ~cpu_full;
    assign cpu_pop   = (grant == GNT_CPU);
    assign mon_ready = (grant == GNT_MON);
    assign echo_drop = echo_drop_q;
    assign cpu_ovf   = cpu_ovf_q;
    assign tx_wten   = tx_wten_q;
    assign tx_wdata  = tx_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Vector table, directed corner sequences and randomized traffic
//           against a queue-based reference model of uart_tx_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] echo_char, mon_char, cpu_char, tx_wdata;
    logic       echo_en, mon_valid, cpu_we, tx_fifo_full;
    logic       echo_drop, mon_ready, cpu_full, cpu_ovf, tx_wten;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CPU_FIFO_AW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .echo_char    (echo_char),
        .echo_en      (echo_en),
        .echo_drop    (echo_drop),
        .mon_char     (mon_char),
        .mon_valid    (mon_valid),
        .mon_ready    (mon_ready),
        .cpu_char     (cpu_char),
        .cpu_we       (cpu_we),
        .cpu_full     (cpu_full),
        .cpu_ovf      (cpu_ovf),
        .tx_fifo_full (tx_fifo_full),
        .tx_wdata     (tx_wdata),
        .tx_wten      (tx_wten)
    );

    typedef struct {
        logic       r, ee;
        logic [7:0] ec;
        logic       mv;
        logic [7:0] mc;
        logic       we;
        logic [7:0] wc;
        logic       txf;
        logic       emr, ewt;
        logic [7:0] ewd;
        logic       efull, eovf, edrop;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a character queue for the CPU buffer, one echo slot,
    // and a flag recording whether the CPU won the last shared round.
    bit         m_hv = 0;
    logic [7:0] m_hc = '0;
    logic [7:0] m_q[$];
    bit         m_last_cpu = 1;
    bit         m_wrote = 0;
    logic [7:0] m_wd = '0;
    bit         m_drop = 0;
    bit         m_ovf = 0;
    byte        last_pick = 0;

    logic [7:0] got[$];
    int         drops;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic byte model_pick();
        if (rst || tx_fifo_full || m_wrote) return 0;
        if (m_hv) return "E";
        if (mon_valid && m_q.size() > 0) return m_last_cpu ? "M" : "C";
        if (mon_valid) return "M";
        if (m_q.size() > 0) return "C";
        return 0;
    endfunction

    task automatic model_update(input byte g);
        bit hv_before   = m_hv;
        bit full_before = (m_q.size() == 4);
        m_drop = 0;
        if (rst) begin
            m_hv = 0; m_q.delete(); m_last_cpu = 1; m_wrote = 0; m_ovf = 0; m_wd = '0;
            return;
        end
        m_wrote = (g != 0);
        if (g == "E") begin m_wd = m_hc; m_hv = 0; end
        if (g == "M") begin m_wd = mon_char; m_last_cpu = 0; end
        if (g == "C") begin m_wd = m_q.pop_front(); m_last_cpu = 1; end
        if (echo_en) begin
            if (!hv_before || g == "E") begin m_hc = echo_char; m_hv = 1; end
            else m_drop = 1;
        end
        if (cpu_we) begin
            if (full_before) m_ovf = 1;
            else m_q.push_back(cpu_char);
        end
    endtask

    // One clock: sample combinational mon_ready at the falling edge, advance
    // the model on the rising edge, return 1 time unit later.
    task automatic tick(output logic mr);
        byte g;
        @(negedge clk);
        mr = mon_ready;
        g  = model_pick();
        last_pick = g;
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic tick_obs();
        logic mr;
        tick(mr);
        if (tx_wten === 1'b1) got.push_back(tx_wdata);
        if (echo_drop === 1'b1) drops++;
    endtask

    task automatic idle_inputs();
        rst = 0; echo_en = 0; echo_char = '0; mon_valid = 0; mon_char = '0;
        cpu_we = 0; cpu_char = '0; tx_fifo_full = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick_obs();
        tick_obs();
        rst = 0;
    endtask

    task automatic add(input logic r, ee, input logic [7:0] ec, input logic mv,
                       input logic [7:0] mc, input logic we, input logic [7:0] wc,
                       input logic txf, emr, ewt, input logic [7:0] ewd,
                       input logic efull, eovf, edrop);
        vec_t v;
        v.r = r; v.ee = ee; v.ec = ec; v.mv = mv; v.mc = mc; v.we = we; v.wc = wc;
        v.txf = txf; v.emr = emr; v.ewt = ewt; v.ewd = ewd;
        v.efull = efull; v.eovf = eovf; v.edrop = edrop;
        vecs.push_back(v);
    endtask

    initial begin
        logic mr;
        idle_inputs();
        rst = 1;

        // Reset, then ten idle cycles.
        add(1,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        add(1,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        for (int i = 0; i < 10; i++) add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        // Single monitor source; the next character must wait one cycle.
        add(0,0,8'h00,1,8'h41,0,8'h00,0, 1,1,8'h41,0,0,0);
        add(0,0,8'h00,1,8'h45,0,8'h00,0, 0,0,8'h00,0,0,0);
        add(0,0,8'h00,1,8'h45,0,8'h00,0, 1,1,8'h45,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        // One CPU character so the CPU owns the last shared round.
        add(0,0,8'h00,0,8'h00,1,8'h50,0, 0,0,8'h00,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,1,8'h50,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        // Contention: echo 0D, monitor 42, CPU 43/44.
        add(0,1,8'h0D,0,8'h00,1,8'h43,0, 0,0,8'h00,0,0,0);
        add(0,0,8'h00,1,8'h42,1,8'h44,0, 0,1,8'h0D,0,0,0);
        add(0,0,8'h00,1,8'h42,0,8'h00,0, 0,0,8'h00,0,0,0);
        add(0,0,8'h00,1,8'h42,0,8'h00,0, 1,1,8'h42,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,1,8'h43,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,1,8'h44,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        // Echo grant and reload in the same cycle: both characters survive.
        add(0,1,8'h71,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        add(0,1,8'h72,0,8'h00,0,8'h00,0, 0,1,8'h71,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,1,8'h72,0,0,0);
        add(0,0,8'h00,0,8'h00,0,8'h00,0, 0,0,8'h00,0,0,0);

        foreach (vecs[i]) begin
            rst = vecs[i].r; echo_en = vecs[i].ee; echo_char = vecs[i].ec;
            mon_valid = vecs[i].mv; mon_char = vecs[i].mc;
            cpu_we = vecs[i].we; cpu_char = vecs[i].wc; tx_fifo_full = vecs[i].txf;
            tick(mr);
            chk($sformatf("row%0d_mon_ready", i), mr, vecs[i].emr);
            chk($sformatf("row%0d_tx_wten", i), tx_wten, vecs[i].ewt);
            if (vecs[i].ewt || vecs[i].r)
                chk($sformatf("row%0d_tx_wdata", i), tx_wdata, vecs[i].ewd);
            chk($sformatf("row%0d_cpu_full", i), cpu_full, vecs[i].efull);
            chk($sformatf("row%0d_cpu_ovf", i), cpu_ovf, vecs[i].eovf);
            chk($sformatf("row%0d_echo_drop", i), echo_drop, vecs[i].edrop);
        end

        // CPU overflow while the TX FIFO is full.
        do_reset();
        tx_fifo_full = 1;
        for (int i = 0; i < 5; i++) begin
            cpu_we = 1; cpu_char = 8'h30 + 8'(i);
            tick_obs();
            if (i == 2) chk("ovf_full_after3", cpu_full, 1'b0);
            if (i == 3) begin
                chk("ovf_full_after4", cpu_full, 1'b1);
                chk("ovf_sticky_after4", cpu_ovf, 1'b0);
            end
            if (i == 4) chk("ovf_sticky_after5", cpu_ovf, 1'b1);
        end
        cpu_we = 0;
        got.delete();
        for (int i = 0; i < 3; i++) tick_obs();
        chk("ovf_stalled_writes", got.size(), 0);
        tx_fifo_full = 0;
        for (int i = 0; i < 16; i++) tick_obs();
        chk("ovf_write_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("ovf_char%0d", i), got[i], 8'h30 + 8'(i));
        chk("ovf_full_drained", cpu_full, 1'b0);
        chk("ovf_still_sticky", cpu_ovf, 1'b1);

        // Echo overflow while stalled.
        do_reset();
        got.delete(); drops = 0;
        tx_fifo_full = 1;
        echo_en = 1; echo_char = 8'h61; tick_obs();
        echo_char = 8'h62; tick_obs();
        echo_en = 0;
        for (int i = 0; i < 3; i++) tick_obs();
        chk("echo_stalled_writes", got.size(), 0);
        tx_fifo_full = 0;
        for (int i = 0; i < 8; i++) tick_obs();
        chk("echo_drop_pulses", drops, 1);
        chk("echo_write_count", got.size(), 1);
        if (got.size() > 0) chk("echo_char", got[0], 8'h61);

        // Reset with characters buffered discards them.
        do_reset();
        tx_fifo_full = 1;
        for (int i = 0; i < 3; i++) begin
            cpu_we = 1; cpu_char = 8'h60 + 8'(i); tick_obs();
        end
        cpu_we = 0; tx_fifo_full = 0; rst = 1;
        tick_obs();
        tick_obs();
        rst = 0;
        got.delete();
        for (int i = 0; i < 6; i++) tick_obs();
        chk("rst_no_writes", got.size(), 0);
        chk("rst_cpu_full", cpu_full, 1'b0);
        cpu_we = 1; cpu_char = 8'h55; tick_obs();
        cpu_we = 0;
        for (int i = 0; i < 6; i++) tick_obs();
        chk("rst_write_count", got.size(), 1);
        if (got.size() > 0) chk("rst_first_char", got[0], 8'h55);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst          = ($urandom % 200) == 0;
            tx_fifo_full = ($urandom % 4) == 0;
            echo_en      = ($urandom % 6) == 0;
            echo_char    = 8'($urandom);
            cpu_we       = ($urandom % 3) == 0;
            cpu_char     = 8'($urandom);
            if (!mon_valid) begin
                mon_valid = ($urandom % 3) == 0;
                mon_char  = 8'($urandom);
            end
            tick(mr);
            chk($sformatf("rnd%0d_mon_ready", c), mr, (last_pick == "M"));
            chk($sformatf("rnd%0d_tx_wten", c), tx_wten, m_wrote);
            if (m_wrote) chk($sformatf("rnd%0d_tx_wdata", c), tx_wdata, m_wd);
            chk($sformatf("rnd%0d_cpu_full", c), cpu_full, (m_q.size() == 4));
            chk($sformatf("rnd%0d_cpu_ovf", c), cpu_ovf, m_ovf);
            chk($sformatf("rnd%0d_echo_drop", c), echo_drop, m_drop);
            if (last_pick == "M") mon_valid = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
